// File: rtl/pot_smoother.sv
// Boxcar-averages each ADC channel over 2^AVG_LOG2 valid pulses, then applies a hysteresis deadband.
// Latency valid->pot_out[ch]: CHANNELS+1+ch edges; no backpressure, a valid while busy is dropped and sets sticky overrun.
module pot_smoother #(
  parameter int CHANNELS = 2,
  parameter int N        = 10,
  parameter int AVG_LOG2 = 3,
  parameter int HYST     = 4
) (
  input  logic                         SCLK,
  input  logic                         reset_n,
  input  logic                         valid,
  input  logic [CHANNELS-1:0][N-1:0]   adc_in,
  output logic [CHANNELS-1:0][N-1:0]   pot_out,
  output logic [CHANNELS-1:0]          pot_changed,
  output logic                         ready,
  output logic                         overrun
);

  localparam int AW = N + AVG_LOG2;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t                        state, state_nxt;
  logic [IW-1:0]                 idx;
  logic [AVG_LOG2-1:0]           count;
  logic [CHANNELS-1:0][N-1:0]    snap;
  logic [CHANNELS-1:0][AW-1:0]   acc;

  logic                          last_ch;
  logic                          win_done;
  logic [N-1:0]                  avg;
  logic [N-1:0]                  pot_cur;
  logic [N:0]                    avg_x, pot_x;
  logic                          load;

  assign last_ch  = (idx == IW'(CHANNELS - 1));
  assign win_done = (count == '1);
  assign avg      = acc[idx][AW-1:AVG_LOG2];
  assign pot_cur  = pot_out[idx];
  assign avg_x    = {1'b0, avg};
  assign pot_x    = {1'b0, pot_cur};

  // Endpoints bypass the deadband so full-scale and zero are always reachable.
  assign load = !ready
             || (avg_x >= pot_x + (N+1)'(HYST))
             || (avg_x + (N+1)'(HYST) <= pot_x)
             || (((avg == '0) || (avg == '1)) && (avg != pot_cur));

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = ACCUM;
      ACCUM:   if (last_ch) state_nxt = win_done ? UPDATE : IDLE;
      UPDATE:  if (last_ch) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      count       <= '0;
      snap        <= '0;
      acc         <= '0;
      pot_out     <= '0;
      pot_changed <= '0;
      ready       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pot_changed <= '0;
      if (valid && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (valid) begin
            snap <= adc_in;
            idx  <= '0;
          end
        end
        ACCUM: begin
          acc[idx] <= acc[idx] + AW'(snap[idx]);
          if (last_ch) begin
            count <= count + 1'b1;
            idx   <= '0;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        UPDATE: begin
          if (load) begin
            pot_out[idx]     <= avg;
            pot_changed[idx] <= 1'b1;
          end
          acc[idx] <= '0;
          if (last_ch) begin
            ready <= 1'b1;
            idx   <= '0;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_smoother.sv
// Randomized scoreboard bench for pot_smoother: window-level reference model feeds an expected-event queue.
module tb_pot_smoother;

  localparam int C    = 2;
  localparam int N    = 10;
  localparam int AL   = 3;
  localparam int HYST = 4;
  localparam int WIN  = 1 << AL;
  localparam int MAXV = (1 << N) - 1;
  localparam int BIG  = 32'h7fffffff;

  logic                 SCLK = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 valid = 1'b0;
  logic [C-1:0][N-1:0]  adc_in = '0;
  logic [C-1:0][N-1:0]  pot_out;
  logic [C-1:0]         pot_changed;
  logic                 ready;
  logic                 overrun;

  pot_smoother #(.CHANNELS(C), .N(N), .AVG_LOG2(AL), .HYST(HYST)) dut (
    .SCLK(SCLK),
    .reset_n(reset_n),
    .valid(valid),
    .adc_in(adc_in),
    .pot_out(pot_out),
    .pot_changed(pot_changed),
    .ready(ready),
    .overrun(overrun)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    int ch;
    int val;
    int edge_n;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  int  mdl_pot [C];
  int  m_final [C];
  int  sum     [C];
  int  nsamp;
  bit  m_ready;
  int  ready_at;
  int  ovr_edge;
  int  busy_until;

  always @(posedge SCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic mreset();
    sb.delete();
    for (int c = 0; c < C; c++) begin
      mdl_pot[c] = 0;
      m_final[c] = 0;
      sum[c]     = 0;
    end
    nsamp      = 0;
    m_ready    = 0;
    ready_at   = BIG;
    ovr_edge   = BIG;
    busy_until = 0;
  endtask

  // Reference: a valid at edge k is dropped if the block is still working on an earlier one;
  // every WIN accepted pulses the per-channel mean is compared against the last published value.
  task automatic model_valid(input int k, input int a0, input int a1);
    int d [C];
    int avg, p;
    ev_t ev;
    d[0] = a0;
    d[1] = a1;
    if (k <= busy_until) begin
      if (ovr_edge == BIG) ovr_edge = k;
    end else begin
      nsamp++;
      busy_until = k + C;
      for (int c = 0; c < C; c++) sum[c] += d[c];
      if (nsamp == WIN) begin
        busy_until = k + 2 * C;
        for (int c = 0; c < C; c++) begin
          avg = sum[c] / WIN;
          p   = m_final[c];
          if (!m_ready || avg >= p + HYST || avg + HYST <= p ||
              ((avg == 0 || avg == MAXV) && avg != p)) begin
            ev.ch = c; ev.val = avg; ev.edge_n = k + C + 1 + c;
            sb.push_back(ev);
            m_final[c] = avg;
          end
          sum[c] = 0;
        end
        nsamp = 0;
        if (!m_ready) begin
          m_ready  = 1;
          ready_at = k + 2 * C;
        end
      end
    end
  endtask

  always @(negedge SCLK) begin
    logic [C-1:0] mask;
    ev_t          ev;
    mask = '0;
    while (sb.size() > 0 && sb[0].edge_n == cyc) begin
      ev = sb.pop_front();
      mask[ev.ch]     = 1'b1;
      mdl_pot[ev.ch]  = ev.val;
    end
    chk("pot_changed", 32'(pot_changed), int'(mask));
    for (int c = 0; c < C; c++) chk("pot_out", 32'(pot_out[c]), mdl_pot[c]);
    chk("ready", 32'(ready), (cyc >= ready_at) ? 1 : 0);
    chk("overrun", 32'(overrun), (cyc >= ovr_edge) ? 1 : 0);
  end

  task automatic pulse(input int a0, input int a1, input int hold);
    @(posedge SCLK); #1;
    adc_in[0] = a0[N-1:0];
    adc_in[1] = a1[N-1:0];
    valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      model_valid(cyc + 1, a0, a1);
      @(posedge SCLK); #1;
    end
    valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(24, 29)) @(posedge SCLK);
  endtask

  task automatic window(input int a0, input int a1);
    repeat (WIN) begin
      pulse(a0, a1, 1);
      gap();
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  initial begin
    int b0, b1;
    mreset();
    repeat (3) @(posedge SCLK);
    #1 reset_n = 1'b1;
    gap();

    // Partial window, then reset while the block is accumulating.
    repeat (3) begin pulse(700, 200, 1); gap(); end
    pulse(700, 200, 1);
    reset_n = 1'b0;
    mreset();
    repeat (3) @(posedge SCLK);
    #1 reset_n = 1'b1;
    gap();

    window(512, 300);
    window(514, 298);
    window(520, 290);

    for (int i = 0; i < WIN; i++) begin
      pulse(100 + i, 290, 1);
      gap();
    end

    window(1021, 500);
    window(1023, 500);
    window(2, 500);
    window(0, 500);

    // Back-to-back valid: the second is dropped and overrun latches.
    pulse(600, 600, 2);
    gap();
    repeat (WIN - 1) begin pulse(600, 600, 1); gap(); end

    repeat (6) begin
      b0 = ($urandom_range(0, 3) == 0) ? MAXV : int'($urandom_range(0, MAXV));
      b1 = ($urandom_range(0, 3) == 0) ? 0    : int'($urandom_range(0, MAXV));
      repeat (WIN) begin
        pulse(clamp(b0 + int'($urandom_range(0, 12)) - 6),
              clamp(b1 + int'($urandom_range(0, 12)) - 6), 1);
        gap();
      end
    end

    repeat (60) @(posedge SCLK);
    #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
